// File: rtl/if_id_queue_pkg.sv
// Shared widths and helper types for the IF/ID instruction queue.
package if_id_queue_pkg;

  // Width constants for the instruction-address bus and the instruction bus.
  localparam int unsigned IFQ_ADDR_W = 32;
  localparam int unsigned IFQ_INST_W = 32;

  // Bubble value presented to ID when the queue is empty.
  localparam logic [31:0] IFQ_ZERO_WORD = 32'h0000_0000;

  // Per-cycle queue operation, indexed as {pop, push}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

  function automatic q_op_e q_op(input logic push, input logic pop);
    return q_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Queue storage: register array, one synchronous write port, one async read port.
module if_id_queue_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned W     = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write the addressed entry on a push; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: in-order FIFO between fetch and decode with flush.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = IFQ_ADDR_W,
  parameter int unsigned INST_W = IFQ_INST_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  output logic                       if_ready,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = ADDR_W + INST_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [EW-1:0] rd_entry;

  assign if_ready = (count_q != FULL);
  assign id_valid = (count_q != '0);
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready && !flush;
  assign count    = count_q;

  // Empty queue presents the zero word as a bubble.
  assign id_pc   = id_valid ? rd_entry[EW-1:INST_W] : '0;
  assign id_inst = id_valid ? rd_entry[INST_W-1:0]  : '0;

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (PW),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({if_pc, if_inst}),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Next-state for pointers and occupancy; flush empties the queue by aligning the read pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      unique case (q_op(push, pop))
        OP_PUSH: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
        end
        OP_POP: begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end
        OP_BOTH: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State registers; reset overrides flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Occupancy must stay within 0..DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= FULL) else $error("if_id_queue: count overflow");
      if (push && !pop) assert (count_q != FULL) else $error("if_id_queue: push when full");
      if (pop && !push) assert (count_q != '0) else $error("if_id_queue: pop when empty");
    end
  end

endmodule
